updown_counter_param: RTL and testbench

//  Parametrised up/down modulo counter with on-chip button conditioning and run/stop/clear control.

---
 rtl/counter_pkg.sv | 6 +
 rtl/btn_debounce_edge.sv | 37 +++
 rtl/updown_counter_param.sv | 83 ++++++++
 tb/tb_updown_counter_param.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: state encoding and direction constants shared by the up/down counter
package counter_pkg;
  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CLEAR} cnt_state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/btn_debounce_edge.sv
// btn_debounce_edge: synchronise, debounce and rising-edge detect one raw button; a press held through reset stays masked until released
module btn_debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [1:0] valid;
  logic [DW-1:0] stable;
  logic level_d;
  logic armed;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
      valid <= '0;
      stable <= '0;
      level <= 1'b0;
      level_d <= 1'b0;
      armed <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync <= {sync[0], btn_in};
      valid <= {valid[0], 1'b1};
      level_d <= level;
      rise_pulse <= level & ~level_d & armed;
      armed <= armed | (valid[1] & ~sync[1] & ~level);
      stable <= (sync[1] == level || stable == LAST) ? '0 : stable + 1'b1;
      level <= (sync[1] != level && stable == LAST) ? sync[1] : level;
    end
  end
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: button-driven run/stop/clear up/down modulo counter with prescaler, load and terminal-count pulse
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int MAX_COUNT = 10000,
  parameter int CNT_W = $clog2(MAX_COUNT),
  parameter int TICK_DIV = 1,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit WRAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_clear,
  input  logic btn_mode,
  input  logic load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic dir,
  output logic running,
  output logic tc
);
  localparam logic [CNT_W-1:0] TOP = CNT_W'(MAX_COUNT - 1);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  cnt_state_t state, state_n;
  logic [2:0] btn, pulse, unused_lvl;
  logic run_p, clr_p, mode_p;
  logic [PW-1:0] psc;
  logic tick, at_end;
  logic [CNT_W-1:0] count_n;
  logic tc_n;
  assign btn = {btn_mode, btn_clear, btn_run};
  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk(clk),
      .rst(rst),
      .btn_in(btn[g]),
      .level(unused_lvl[g]),
      .rise_pulse(pulse[g])
    );
  end
  assign run_p = pulse[0];
  assign clr_p = pulse[1];
  assign mode_p = pulse[2];
  assign tick = state == ST_RUN && psc == PW'(TICK_DIV - 1);
  assign at_end = dir == DIR_DOWN ? count == '0 : count == TOP;
  always_comb begin
    state_n = state;
    state_n = state == ST_CLEAR ? ST_STOP :
              clr_p ? ST_CLEAR :
              run_p ? (state == ST_RUN ? ST_STOP : ST_RUN) : state;
  end
  always_comb begin
    count_n = count;
    tc_n = 1'b0;
    if (state == ST_CLEAR) begin
      count_n = '0;
    end else if (load) begin
      count_n = load_value > TOP ? TOP : load_value;
    end else if (tick) begin
      tc_n = at_end;
      count_n = at_end ? (WRAP ? (dir == DIR_DOWN ? TOP : '0) : count) :
                (dir == DIR_DOWN ? count - 1'b1 : count + 1'b1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_STOP;
      psc <= '0;
      count <= '0;
      dir <= DIR_UP;
      running <= 1'b0;
      tc <= 1'b0;
    end else begin
      state <= state_n;
      psc <= (state == ST_RUN && state_n == ST_RUN && !tick) ? psc + 1'b1 : '0;
      count <= count_n;
      tc <= tc_n;
      dir <= dir ^ mode_p;
      running <= state_n == ST_RUN;
    end
  end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: scoreboard bench checking a wrapping and a saturating counter against a behavioural model
module tb_updown_counter_param;
  localparam int MAXC = 10;
  localparam int TD = 2;
  localparam int DB = 4;
  typedef struct packed {
    logic [3:0] cw;
    logic [3:0] cs;
    logic d;
    logic r;
    logic tw;
    logic ts;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_run = 1'b0;
  logic btn_clear = 1'b0;
  logic btn_mode = 1'b0;
  logic load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] count_w, count_s;
  logic dir_w, dir_s, running_w, running_s, tc_w, tc_s;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cw, cs, age, edges, st;
  logic dm, tw, ts;
  logic [2:0] pul, lvl, lvl_d, armed, bs;
  logic [15:0] raw_h [3];
  logic [15:0] seen_h [3];
  always #5 clk = ~clk;
  updown_counter_param #(.MAX_COUNT(MAXC), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
    .load(load), .load_value(load_value), .count(count_w), .dir(dir_w), .running(running_w), .tc(tc_w)
  );
  updown_counter_param #(.MAX_COUNT(MAXC), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
    .load(load), .load_value(load_value), .count(count_s), .dir(dir_s), .running(running_s), .tc(tc_s)
  );
  function automatic int stepc(int c, bit down, bit w);
    int n = down ? c - 1 : c + 1;
    if (n < 0 || n >= MAXC) return w ? (n + MAXC) % MAXC : c;
    return n;
  endfunction
  task automatic model(input logic [2:0] b, input logic ld, input int lv, input logic n);
    int nst;
    logic tick, seen;
    if (!n) begin
      cw = 0; cs = 0; age = 0; edges = 0; st = 0;
      dm = 1'b0; tw = 1'b0; ts = 1'b0;
      pul = '0; lvl = '0; lvl_d = '0; armed = '0;
      for (int i = 0; i < 3; i++) begin
        raw_h[i] = '0;
        seen_h[i] = '0;
      end
    end else begin
      tick = st == 1 && age % TD == TD - 1;
      tw = 1'b0;
      ts = 1'b0;
      if (st == 2) begin
        cw = 0;
        cs = 0;
      end else if (ld) begin
        cw = lv >= MAXC ? MAXC - 1 : lv;
        cs = cw;
      end else if (tick) begin
        tw = dm ? cw == 0 : cw == MAXC - 1;
        ts = dm ? cs == 0 : cs == MAXC - 1;
        cw = stepc(cw, dm, 1'b1);
        cs = stepc(cs, dm, 1'b0);
      end
      dm = dm ^ pul[2];
      nst = st == 2 ? 0 : pul[1] ? 2 : pul[0] ? 1 - st : st;
      age = (st == 1 && nst == 1) ? age + 1 : 0;
      st = nst;
      edges++;
      for (int i = 0; i < 3; i++) begin
        raw_h[i] = {raw_h[i][14:0], b[i]};
        seen = edges >= 3 && raw_h[i][2];
        pul[i] = lvl[i] & ~lvl_d[i] & armed[i];
        if (edges >= 3 && !seen && !lvl[i]) armed[i] = 1'b1;
        lvl_d[i] = lvl[i];
        seen_h[i] = {seen_h[i][14:0], seen};
        if (seen_h[i][DB-1:0] == {DB{~lvl[i]}}) lvl[i] = ~lvl[i];
      end
    end
    sb.push_back({4'(cw), 4'(cs), dm, st == 1, tw, ts});
  endtask
  task automatic step(input logic [2:0] b, input logic ld = 1'b0, input logic [3:0] lv = 4'd0, input logic n = 1'b1);
    @(negedge clk);
    {btn_mode, btn_clear, btn_run} = b;
    load = ld;
    load_value = lv;
    rst = n;
    model(b, ld, int'(lv), n);
  endtask
  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got count=%0d dir=%0b running=%0b tc=%0b, expected count=%0d dir=%0b running=%0b tc=%0b",
               nm, $time, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wrap", {count_w, dir_w, running_w, tc_w}, {e.cw, e.d, e.r, e.tw});
        check("sat", {count_s, dir_s, running_s, tc_s}, {e.cs, e.d, e.r, e.ts});
      end
    end
  end
  initial begin
    repeat (3) step(3'b000, 1'b0, 4'd0, 1'b0);
    repeat (6) step(3'b000);
    repeat (20) step(3'b001);
    repeat (10) step(3'b000);
    for (int i = 0; i < 12; i++) step((i / 2) % 2 == 0 ? 3'b001 : 3'b000);
    repeat (12) step(3'b001);
    repeat (10) step(3'b000);
    step(3'b000, 1'b1, 4'd8);
    repeat (8) step(3'b001);
    repeat (14) step(3'b000);
    repeat (8) step(3'b100);
    repeat (8) step(3'b000);
    step(3'b000, 1'b1, 4'd1);
    repeat (14) step(3'b000);
    step(3'b000, 1'b1, 4'd5);
    repeat (8) step(3'b011);
    repeat (10) step(3'b000);
    repeat (8) step(3'b001);
    repeat (8) step(3'b000);
    step(3'b000, 1'b1, 4'd15);
    repeat (5) step(3'b000);
    repeat (2) step(3'b000, 1'b0, 4'd0, 1'b0);
    repeat (5) step(3'b000);
    repeat (2) step(3'b001, 1'b0, 4'd0, 1'b0);
    repeat (20) step(3'b001);
    repeat (10) step(3'b000);
    repeat (8) step(3'b001);
    repeat (10) step(3'b000);
    bs = '0;
    for (int i = 0; i < 4000; i++) begin
      for (int j = 0; j < 3; j++) if ($urandom_range(0, 9) == 0) bs[j] = ~bs[j];
      step(bs, $urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 499) != 0);
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of stimulus, expected one within 2000000 time units");
    $fatal(1);
  end
endmodule
